// File: rtl/invader_grid.sv
// invader_grid: owns the invader alive mask and runs a once-per-frame
// cell-by-cell laser hit scan. The scan goes bottom row first, so the kill
// lands on the invader nearest the player. At most one kill happens per frame.
`timescale 1ns/1ps
module invader_grid #(
   parameter int COLS    = 6,
   parameter int ROWS    = 5,
   parameter int CELL_W  = 32,
   parameter int CELL_H  = 24,
   parameter int INV_W   = 24,
   parameter int INV_H   = 16,
   parameter int PROJ_W  = 2,
   parameter int PROJ_H  = 8,
   parameter int PTS_TOP = 30,
   parameter int PTS_MID = 20,
   parameter int PTS_BOT = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame,
   input  logic                 wave_reset,
   input  logic                 laser_active,
   input  logic [9:0]           laser_x,
   input  logic [9:0]           laser_y,
   input  logic [9:0]           grid_x,
   input  logic [9:0]           grid_y,
   output logic [COLS-1:0]      invader_collision,
   output logic [ROWS*COLS-1:0] alive,
   output logic                 hit_pulse,
   output logic [15:0]          score,
   output logic                 all_dead
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int IW = (ROWS*COLS > 1) ? $clog2(ROWS*COLS) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                state_q, state_d;
   logic [RW-1:0]         row_q, row_d;
   logic [CW-1:0]         col_q, col_d;
   logic [9:0]            lx_q, lx_d, ly_q, ly_d, gx_q, gx_d, gy_q, gy_d;
   logic                  found_q, found_d;
   logic [ROWS*COLS-1:0]  alive_q, alive_d;
   logic [15:0]           score_q, score_d;
   logic [COLS-1:0]       coll_q, coll_d;
   logic                  hit_q, hit_d;
   logic                  all_dead_q, all_dead_d;

   logic [10:0]           cx, cy, lx, ly;
   logic [IW-1:0]         cell_idx;
   logic                  overlap;
   logic [15:0]           pts;
   logic [16:0]           score_sum;

   // Current cell geometry and overlap test; 11-bit math so sums never wrap
   always_comb begin
      lx       = {1'b0, lx_q};
      ly       = {1'b0, ly_q};
      cx       = {1'b0, gx_q} + 11'(col_q) * 11'(CELL_W);
      cy       = {1'b0, gy_q} + 11'(row_q) * 11'(CELL_H);
      cell_idx = IW'(row_q) * IW'(COLS) + IW'(col_q);
      overlap  = (lx < cx + 11'(INV_W)) && (cx < lx + 11'(PROJ_W)) &&
                 (ly < cy + 11'(INV_H)) && (cy < ly + 11'(PROJ_H));
      if (row_q == '0)               pts = 16'(PTS_TOP);
      else if (row_q <= RW'(2))      pts = 16'(PTS_MID);
      else                           pts = 16'(PTS_BOT);
      score_sum = {1'b0, score_q} + {1'b0, pts};
   end

   // Scan FSM next-state and datapath; wave_reset overrides everything but score
   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      col_d      = col_q;
      lx_d       = lx_q;
      ly_d       = ly_q;
      gx_d       = gx_q;
      gy_d       = gy_q;
      found_d    = found_q;
      alive_d    = alive_q;
      score_d    = score_q;
      coll_d     = coll_q;
      hit_d      = 1'b0;
      all_dead_d = all_dead_q;
      case (state_q)
         IDLE: begin
            if (frame) begin
               coll_d = '0;
               if (laser_active) begin
                  lx_d    = laser_x;
                  ly_d    = laser_y;
                  gx_d    = grid_x;
                  gy_d    = grid_y;
                  found_d = 1'b0;
                  row_d   = ROW_LAST;
                  col_d   = '0;
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            if (overlap && alive_q[cell_idx] && !found_q) begin
               alive_d[cell_idx] = 1'b0;
               found_d           = 1'b1;
               coll_d[col_q]     = 1'b1;
               hit_d             = 1'b1;
               score_d           = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            end
            if (col_q == COL_LAST) begin
               col_d = '0;
               if (row_q == '0) state_d = DONE;
               else             row_d   = row_q - RW'(1);
            end else begin
               col_d = col_q + CW'(1);
            end
         end
         DONE: begin
            all_dead_d = (alive_q == '0);
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (wave_reset) begin
         alive_d    = '1;
         coll_d     = '0;
         all_dead_d = 1'b0;
         hit_d      = 1'b0;
         score_d    = score_q;
         state_d    = IDLE;
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         row_q      <= '0;
         col_q      <= '0;
         lx_q       <= '0;
         ly_q       <= '0;
         gx_q       <= '0;
         gy_q       <= '0;
         found_q    <= 1'b0;
         alive_q    <= '1;
         score_q    <= '0;
         coll_q     <= '0;
         hit_q      <= 1'b0;
         all_dead_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_q      <= row_d;
         col_q      <= col_d;
         lx_q       <= lx_d;
         ly_q       <= ly_d;
         gx_q       <= gx_d;
         gy_q       <= gy_d;
         found_q    <= found_d;
         alive_q    <= alive_d;
         score_q    <= score_d;
         coll_q     <= coll_d;
         hit_q      <= hit_d;
         all_dead_q <= all_dead_d;
      end
   end

   assign invader_collision = coll_q;
   assign alive             = alive_q;
   assign hit_pulse         = hit_q;
   assign score             = score_q;
   assign all_dead          = all_dead_q;

endmodule
